// File: rtl/tetris_pkg.sv
// Shared definitions for the tetris move scheduler: phase encodings,
// command indices, board dimensions and the fixed-priority move picker.
package tetris_pkg;

  // Game phases, also driven directly onto the phase output.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } phase_e;

  // Bit positions of the move commands inside every 4-bit command vector.
  localparam int CMD_UP    = 0;
  localparam int CMD_LEFT  = 1;
  localparam int CMD_RIGHT = 2;
  localparam int CMD_DOWN  = 3;
  localparam int NUM_CMD   = 4;

  // Playfield size of the game core this block drives.
  localparam int BOARD_W = 10;
  localparam int BOARD_H = 23;

  // Pick at most one command: gravity-down, up, left, right, key-down.
  // Gravity and key-down both land on the down bit.
  function automatic logic [NUM_CMD-1:0] pick_winner(
    input logic               i_grav,
    input logic [NUM_CMD-1:0] i_req
  );
    logic [NUM_CMD-1:0] win;
    win = '0;
    if (i_grav)                win[CMD_DOWN]  = 1'b1;
    else if (i_req[CMD_UP])    win[CMD_UP]    = 1'b1;
    else if (i_req[CMD_LEFT])  win[CMD_LEFT]  = 1'b1;
    else if (i_req[CMD_RIGHT]) win[CMD_RIGHT] = 1'b1;
    else if (i_req[CMD_DOWN])  win[CMD_DOWN]  = 1'b1;
    return win;
  endfunction

endpackage

// File: rtl/tetris_key_repeat.sv
// Per-key request generator: rising-edge detection, plus a hold/repeat
// counter when TETRIS_AUTO_REPEAT_EN is defined. o_req is a one-cycle
// strobe, combinational from i_key so a fresh press can issue on the
// same edge that first samples it.
module tetris_key_repeat
`ifdef TETRIS_AUTO_REPEAT_EN
#(
  parameter int CNT_W       = 26,
  parameter bit REPEAT_EN   = 1'b1,
  parameter int REPEAT_DLY  = 12500000,
  parameter int REPEAT_RATE = 2500000
)
`endif
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_key,
  output logic o_req
);

  logic r_key_q;
  logic w_press;

  assign w_press = i_key & ~r_key_q;

  // Delay the key by one cycle so a rising edge can be detected.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_key_q <= 1'b0;
    else        r_key_q <= i_key;
  end

`ifdef TETRIS_AUTO_REPEAT_EN
  if (REPEAT_EN) begin : g_rep
    logic [CNT_W-1:0] r_hold;
    logic             r_rep;
    logic             w_fire;

    // First repeat after REPEAT_DLY held cycles, then every REPEAT_RATE.
    assign w_fire = i_key & (r_rep ? (r_hold == CNT_W'(REPEAT_RATE))
                                   : (r_hold == CNT_W'(REPEAT_DLY)));
    assign o_req  = w_press | w_fire;

    // Count continuous held cycles; release clears the count.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_hold <= '0;
        r_rep  <= 1'b0;
      end else if (!i_key) begin
        r_hold <= '0;
        r_rep  <= 1'b0;
      end else if (w_fire) begin
        r_hold <= CNT_W'(1);
        r_rep  <= 1'b1;
      end else begin
        r_hold <= r_hold + CNT_W'(1);
      end
    end
  end else begin : g_norep
    assign o_req = w_press;
  end
`else
  assign o_req = w_press;
`endif

endmodule

// File: rtl/tetris_move_sched.sv
// Move scheduler in front of the tetris core. Converts four keys and a
// level-dependent gravity timer into one-cycle, one-hot move pulses with
// fixed priority and a minimum low gap, and runs the IDLE/RUN/OVER phases.
// Optional build macro: TETRIS_AUTO_REPEAT_EN adds hold-to-repeat on the
// left, right and down keys.
module tetris_move_sched
  import tetris_pkg::*;
#(
  parameter int CNT_W       = 26,
  parameter int GRAV_PERIOD = 25000000,
  parameter int GRAV_STEP   = 1500000,
  parameter int GRAV_MIN    = 2500000,
  parameter int MOVE_GAP    = 4
`ifdef TETRIS_AUTO_REPEAT_EN
  ,
  parameter int REPEAT_DLY  = 12500000,
  parameter int REPEAT_RATE = 2500000
`endif
)(
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       g_over,
  input  logic [3:0] level,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic [1:0] phase
);

  localparam int GAP_W = (MOVE_GAP < 1) ? 1 : $clog2(MOVE_GAP + 1);
  // Headroom so level*GRAV_STEP cannot overflow before saturation.
  localparam int EW    = CNT_W + 5;

  phase_e               r_phase;
  logic [CNT_W-1:0]     r_grav_cnt;
  logic [GAP_W-1:0]     r_gap_cnt;
  logic                 r_grav_pend;
  logic [NUM_CMD-1:0]   r_pend;
  logic [NUM_CMD-1:0]   r_out;

  logic [NUM_CMD-1:0]   w_keys;
  logic [NUM_CMD-1:0]   w_press;
  logic [NUM_CMD-1:0]   w_req;
  logic [NUM_CMD-1:0]   w_win;
  logic [EW-1:0]        w_prod;
  logic [EW-1:0]        w_diff;
  logic [CNT_W-1:0]     w_eff;
  logic                 w_grav_hit;
  logic                 w_grav_req;

  assign w_keys[CMD_UP]    = key_up;
  assign w_keys[CMD_LEFT]  = key_left;
  assign w_keys[CMD_RIGHT] = key_right;
  assign w_keys[CMD_DOWN]  = key_down;

  // One request generator per key; rotate never auto-repeats.
  for (genvar g = 0; g < NUM_CMD; g++) begin : g_key
    tetris_key_repeat
`ifdef TETRIS_AUTO_REPEAT_EN
    #(
      .CNT_W       (CNT_W),
      .REPEAT_EN   (g != CMD_UP),
      .REPEAT_DLY  (REPEAT_DLY),
      .REPEAT_RATE (REPEAT_RATE)
    )
`endif
    u_key (
      .clk   (clk),
      .rst_n (resetn),
      .i_key (w_keys[g]),
      .o_req (w_press[g])
    );
  end

  // Effective gravity interval: max(PERIOD - level*STEP, MIN), at least 1,
  // saturated to the counter width.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_prod = EW'(level) * EW'(GRAV_STEP);
    w_diff = EW'(GRAV_MIN);
    w_eff  = '1;
    if (EW'(GRAV_PERIOD) > w_prod + EW'(GRAV_MIN))
      w_diff = EW'(GRAV_PERIOD) - w_prod;
    if (w_diff == '0)
      w_diff = EW'(1);
    if (w_diff <= EW'({CNT_W{1'b1}}))
      w_eff = CNT_W'(w_diff);
  end

  // Gravity fires on the wrap cycle itself so a coinciding key-down merges
  // into the same pulse. ">=" lets a level increase take effect at once
  // when the count is already past the shorter interval.
  assign w_grav_hit = (r_grav_cnt >= (w_eff - CNT_W'(1)));
  assign w_grav_req = r_grav_pend | w_grav_hit;
  assign w_req      = r_pend | w_press;
  assign w_win      = (r_gap_cnt == '0) ? pick_winner(w_grav_req, w_req) : '0;

  // Phase FSM with registered move outputs, gravity timer, gap and pends.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_phase     <= IDLE;
      r_out       <= '0;
      r_grav_cnt  <= '0;
      r_gap_cnt   <= '0;
      r_grav_pend <= 1'b0;
      r_pend      <= '0;
    end else begin
      case (r_phase)
        RUN: begin
          if (g_over) begin
            // Game over wins over any issue decision and drops all pends.
            r_phase     <= OVER;
            r_out       <= '0;
            r_grav_cnt  <= '0;
            r_gap_cnt   <= '0;
            r_grav_pend <= 1'b0;
            r_pend      <= '0;
          end else begin
            r_out       <= w_win;
            r_pend      <= w_req & ~w_win;
            r_grav_pend <= w_grav_req & ~w_win[CMD_DOWN];
            r_grav_cnt  <= w_grav_hit ? '0 : r_grav_cnt + CNT_W'(1);
            if (|w_win)
              r_gap_cnt <= GAP_W'(MOVE_GAP);
            else if (r_gap_cnt != '0)
              r_gap_cnt <= r_gap_cnt - GAP_W'(1);
          end
        end
        IDLE, OVER: begin
          // Outputs quiet, timer held at 0, key presses discarded; this
          // also leaves everything clear for the next entry into RUN.
          r_out       <= '0;
          r_grav_cnt  <= '0;
          r_gap_cnt   <= '0;
          r_grav_pend <= 1'b0;
          r_pend      <= '0;
          if (start)
            r_phase <= RUN;
        end
        default: begin
          r_phase     <= IDLE;
          r_out       <= '0;
          r_grav_cnt  <= '0;
          r_gap_cnt   <= '0;
          r_grav_pend <= 1'b0;
          r_pend      <= '0;
        end
      endcase
    end
  end

  assign up    = r_out[CMD_UP];
  assign down  = r_out[CMD_DOWN];
  assign left  = r_out[CMD_LEFT];
  assign right = r_out[CMD_RIGHT];
  assign phase = r_phase;

endmodule

// File: tb/tb_tetris_move_sched.sv
// Self-checking bench for tetris_move_sched. Every expected move pulse is
// pushed into a scoreboard (edge number + command) when the stimulus that
// causes it is driven; a negedge monitor pops matching pulses and flags
// unexpected or missing ones. Edge numbers count rising clock edges.
// Honours TETRIS_AUTO_REPEAT_EN for the auto-repeat scenario.
module tb_tetris_move_sched;
  import tetris_pkg::*;

  logic       clk;
  logic       resetn;
  logic       start;
  logic       key_up;
  logic       key_down;
  logic       key_left;
  logic       key_right;
  logic       g_over;
  logic [3:0] level;
  logic       up;
  logic       down;
  logic       left;
  logic       right;
  logic [1:0] phase;

  typedef struct {
    int cyc;
    int cmd;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   g_last;
  int   eff;

  logic [3:0] obs;
  bit         found;
  int         idx;

  tetris_move_sched #(
    .GRAV_PERIOD (20),
    .GRAV_STEP   (2),
    .GRAV_MIN    (6),
    .MOVE_GAP    (3)
`ifdef TETRIS_AUTO_REPEAT_EN
    ,
    .REPEAT_DLY  (8),
    .REPEAT_RATE (4)
`endif
  ) u_dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .key_up    (key_up),
    .key_down  (key_down),
    .key_left  (key_left),
    .key_right (key_right),
    .g_over    (g_over),
    .level     (level),
    .up        (up),
    .down      (down),
    .left      (left),
    .right     (right),
    .phase     (phase)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: outputs registered at edge cyc are seen here.
  always @(negedge clk) begin : monitor
    obs = '0;
    obs[CMD_UP]    = up;
    obs[CMD_LEFT]  = left;
    obs[CMD_RIGHT] = right;
    obs[CMD_DOWN]  = down;
    for (int b = 0; b < NUM_CMD; b++) begin
      if (obs[b] === 1'b1) begin
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < sb.size(); i++)
          if (!found && sb[i].cyc == cyc && sb[i].cmd == b) begin
            found = 1'b1;
            idx   = i;
          end
        n_checks++;
        if (found) begin
          n_pass++;
          sb.delete(idx);
        end else
          $display("FAIL pulse_unexpected: edge %0d cmd %0d observed 1, required 0", cyc, b);
      end
    end
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].cyc <= cyc) begin
        n_checks++;
        $display("FAIL pulse_missing: edge %0d cmd %0d observed 0, required 1", sb[i].cyc, sb[i].cmd);
        sb.delete(i);
      end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, observed no finish, required finish");
    $fatal(1, "time limit");
  end

  task automatic push(input int c, input int cmd);
    exp_t e;
    e.cyc = c;
    e.cmd = cmd;
    sb.push_back(e);
  endtask

  // Schedule the next n gravity pulses at the current interval.
  task automatic push_grav(input int n);
    repeat (n) begin
      g_last = g_last + eff;
      push(g_last, CMD_DOWN);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Call at a negedge; returns the edge at which start is sampled.
  task automatic do_start(output int s);
    start = 1'b1;
    s     = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; g_over = 1'b0; level = 4'd0;
    key_up = 1'b0; key_down = 1'b0; key_left = 1'b0; key_right = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({up, down, left, right} !== 4'b0000)
      $display("FAIL reset_outputs: observed %b, required 0000", {up, down, left, right});
    else n_pass++;
    n_checks++;
    if (phase !== 2'd0) $display("FAIL reset_phase: observed %0d, required 0", phase);
    else n_pass++;
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if (phase !== 2'd0) $display("FAIL idle_hold_phase: observed %0d, required 0", phase);
    else n_pass++;
  endtask

  task automatic test_gravity();
    int s;
    do_start(s);
    n_checks++;
    if (phase !== 2'd1) $display("FAIL start_phase: observed %0d, required 1", phase);
    else n_pass++;
    eff    = 20;
    g_last = s;
    push_grav(3);
    wait_until(g_last);
  endtask

  // Level changes right after a pulse, while the counter is at 0.
  task automatic test_level();
    level = 4'd15; eff = 6;  push_grav(3); wait_until(g_last);
    level = 4'd3;  eff = 14; push_grav(3); wait_until(g_last);
    level = 4'd0;  eff = 20; push_grav(1); wait_until(g_last);
  endtask

  task automatic test_left_right();
    int g;
    g = g_last;
    wait_until(g + 4);
    key_left = 1'b1; key_right = 1'b1;
    push(g + 5, CMD_LEFT);
    push(g + 9, CMD_RIGHT);
    wait_until(g + 7);
    key_left = 1'b0; key_right = 1'b0;
    push_grav(1);
    wait_until(g_last);
  endtask

  // All keys at once; the key-down pulse blocks the gravity wrap via the
  // gap, so gravity stays pending and issues one edge late.
  task automatic test_priority();
    int g;
    g = g_last;
    wait_until(g + 4);
    key_up = 1'b1; key_left = 1'b1; key_right = 1'b1; key_down = 1'b1;
    push(g + 5,  CMD_UP);
    push(g + 9,  CMD_LEFT);
    push(g + 13, CMD_RIGHT);
    push(g + 17, CMD_DOWN);
    push(g + 21, CMD_DOWN);
    push(g + 40, CMD_DOWN);
    g_last = g + 40;
    wait_until(g + 6);
    key_up = 1'b0; key_left = 1'b0; key_right = 1'b0; key_down = 1'b0;
    wait_until(g_last);
  endtask

  task automatic test_hold_up();
    int g;
    g = g_last;
    wait_until(g + 4);
    key_up = 1'b1;
    push(g + 5, CMD_UP);
    push_grav(3);
    wait_until(g + 54);
    key_up = 1'b0;
    wait_until(g_last);
  endtask

`ifdef TETRIS_AUTO_REPEAT_EN
  // Left held 30 cycles from edge n. Gravity lands at n+4 (between repeats)
  // and at n+24, where it wins; the losing left repeat stays pending and
  // merges with the n+28 repeat into one pulse.
  task automatic test_repeat();
    int g;
    int n;
    g = g_last;
    n = g + 16;
    wait_until(n - 1);
    key_left = 1'b1;
    push(n,      CMD_LEFT);
    push(n + 4,  CMD_DOWN);
    push(n + 8,  CMD_LEFT);
    push(n + 12, CMD_LEFT);
    push(n + 16, CMD_LEFT);
    push(n + 20, CMD_LEFT);
    push(n + 24, CMD_DOWN);
    push(n + 28, CMD_LEFT);
    g_last = g + 40;
    push_grav(1);
    wait_until(n + 29);
    key_left = 1'b0;
    wait_until(g_last);
  endtask
`endif

  task automatic test_grav_keydown_merge();
    int g;
    g = g_last;
    wait_until(g + 19);
    key_down = 1'b1;
    push(g + 20, CMD_DOWN);
    g_last = g + 20;
    push_grav(1);
    wait_until(g + 22);
    key_down = 1'b0;
    wait_until(g_last);
  endtask

  task automatic test_game_over();
    int g;
    int s;
    g = g_last;
    wait_until(g + 4);
    key_left = 1'b1; key_right = 1'b1;
    push(g + 5, CMD_LEFT);
    wait_until(g + 8);
    g_over = 1'b1;
    wait_until(g + 9);
    n_checks++;
    if (phase !== 2'd2) $display("FAIL over_phase: observed %0d, required 2", phase);
    else n_pass++;
    key_left = 1'b0; key_right = 1'b0;
    wait_until(g + 30);
    g_over   = 1'b0;
    key_left = 1'b1;
    wait_until(g + 33);
    key_left = 1'b0;
    wait_until(g + 35);
    n_checks++;
    if (phase !== 2'd2) $display("FAIL over_hold_phase: observed %0d, required 2", phase);
    else n_pass++;
    do_start(s);
    n_checks++;
    if (phase !== 2'd1) $display("FAIL restart_phase: observed %0d, required 1", phase);
    else n_pass++;
    eff    = 20;
    g_last = s;
    push_grav(1);
    wait_until(g_last);
  endtask

  task automatic test_reset_mid_run();
    int g;
    int s;
    g = g_last;
    wait_until(g + 15);
    key_left = 1'b1; key_right = 1'b1;
    push(g + 16, CMD_LEFT);
    push(g + 20, CMD_DOWN);
    wait_until(g + 17);
    key_left = 1'b0; key_right = 1'b0;
    wait_until(g + 20);
    #2 resetn = 1'b0;
    #1;
    n_checks++;
    if ({up, down, left, right} !== 4'b0000)
      $display("FAIL async_reset_outputs: observed %b, required 0000", {up, down, left, right});
    else n_pass++;
    n_checks++;
    if (phase !== 2'd0) $display("FAIL async_reset_phase: observed %0d, required 0", phase);
    else n_pass++;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (25) @(negedge clk);
    n_checks++;
    if (phase !== 2'd0) $display("FAIL post_reset_phase: observed %0d, required 0", phase);
    else n_pass++;
    do_start(s);
    eff    = 20;
    g_last = s;
    push_grav(1);
    wait_until(g_last);
  endtask

  initial begin
    test_reset();
    test_gravity();
    test_level();
    test_left_right();
    test_priority();
    test_hold_up();
`ifdef TETRIS_AUTO_REPEAT_EN
    test_repeat();
`endif
    test_grav_keydown_merge();
    test_game_over();
    test_reset_mid_run();
    repeat (3) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: observed %0d entries left, required 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
